// File: rtl/uart_pkg.sv
// Shared UART definitions: line defaults, beep command bytes and the receiver state encoding.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int UART_BPS_DEF = 9600;

  localparam logic [7:0] CMD_ON_BYTE  = 8'h31;
  localparam logic [7:0] CMD_OFF_BYTE = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_beep_cmd_rx_if.sv
// Serial line in, received byte / strobes / beep level out, plus the receiver state for observation.
interface uart_beep_cmd_rx_if;

  // No handshake: uart_rxd is a free-running line; rx_valid and frame_err are
  // single-cycle strobes with no ready, so consumers must capture on the strobe cycle.
  logic                 uart_rxd;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 beep_flag;
  uart_pkg::rx_state_t  rx_state;

  modport master (
    output uart_rxd,
    input  rx_data, rx_valid, frame_err, beep_flag, rx_state
  );

  modport slave (
    input  uart_rxd,
    output rx_data, rx_valid, frame_err, beep_flag, rx_state
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, start/data/stop FSM, baud and bit counters, shift register.
module uart_rx_core
  import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int UART_BPS = UART_BPS_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output rx_state_t  rx_state
);

    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS - 1;
    localparam logic [12:0] BAUD_END     = 13'(BAUD_CNT_MAX);
    localparam logic [12:0] BAUD_HALF    = 13'(BAUD_CNT_MAX / 2);

    logic        rxd_s1, rxd_s2, rxd_d;
    logic        start_edge;
    logic [12:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    rx_state_t   state;

    // Preset high so reset release on an idle line never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign start_edge = rxd_d & ~rxd_s2;
    assign rx_state   = state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (start_edge) state <= START;
                end
                START: begin
                    if (baud_cnt == BAUD_HALF) begin
                        baud_cnt <= '0;
                        state    <= rxd_s2 ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_END) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxd_s2, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end
                STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (baud_cnt == BAUD_END) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (rxd_s2) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_beep_cmd_rx.sv
// UART command receiver for the beep stage: received '1'/'0' bytes set/clear a held beep enable.
module uart_beep_cmd_rx
  import uart_pkg::*;
#(
    parameter int         CLK_FREQ = CLK_FREQ_DEF,
    parameter int         UART_BPS = UART_BPS_DEF,
    parameter logic [7:0] CMD_ON   = CMD_ON_BYTE,
    parameter logic [7:0] CMD_OFF  = CMD_OFF_BYTE
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    uart_beep_cmd_rx_if.slave  bus
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       beep_flag;
    rx_state_t  rx_state;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_rx_core (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (bus.uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_state  (rx_state)
    );

    // Only good frames reach the decode; framing errors leave the beep level alone.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beep_flag <= 1'b0;
        end else if (rx_valid) begin
            if (rx_data == CMD_ON)       beep_flag <= 1'b1;
            else if (rx_data == CMD_OFF) beep_flag <= 1'b0;
        end
    end

    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.frame_err = frame_err;
    assign bus.beep_flag = beep_flag;
    assign bus.rx_state  = rx_state;

endmodule

// File: tb/tb_uart_beep_cmd_rx.sv
// Directed bench for uart_beep_cmd_rx at an 80-clock bit period (50 MHz / 625 kBd).
module tb_uart_beep_cmd_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 625_000;
  localparam int BIT      = 80;
  // 3 sync/edge + 39 half-bit count + 9 bit periods + 1 register stage
  localparam int LATENCY  = 763;
  localparam int FRAME    = 800;

  logic sys_clk;
  logic sys_rst_n;

  uart_beep_cmd_rx_if bus ();

  uart_beep_cmd_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .CMD_ON   (8'h31),
    .CMD_OFF  (8'h30)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // strobe monitor
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   excl_viol = 0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;
  logic beep_at_valid = 1'b0;
  logic prev_strobe = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.rx_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      beep_at_valid  = bus.beep_flag;
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if ((bus.rx_valid && bus.frame_err) || ((bus.rx_valid || bus.frame_err) && prev_strobe))
      excl_viol++;
    prev_strobe = bus.rx_valid || bus.frame_err;
  end

  int checks = 0;
  int errors = 0;
  int fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic v, input int n);
    bus.uart_rxd = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(stop_bit, BIT);
  endtask

  task automatic settle();
    #1;
  endtask

  int v0;
  int e0;
  logic [7:0] frame_b;

  initial begin
    bus.uart_rxd = 1'b1;
    sys_rst_n    = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_beep_flag", bus.beep_flag, 1'b0);
    check("reset_state", bus.rx_state, IDLE);
    sys_rst_n = 1'b1;
    drive_bit(1'b1, 2 * BIT);
    settle();
    check("no_start_after_reset", bus.rx_state, IDLE);

    // T1: single '1'
    send_frame(8'h31, 1'b1);
    settle();
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_rx_data", bus.rx_data, 8'h31);
    check("t1_latency", last_valid_cyc - fall_cyc, LATENCY);
    check("t1_beep_during_valid", beep_at_valid, 1'b0);
    check("t1_beep_flag", bus.beep_flag, 1'b1);

    // T2: '1' then '0' back to back
    drive_bit(1'b1, 3 * BIT);
    send_frame(8'h31, 1'b1);
    settle();
    check("t2_beep_after_on", bus.beep_flag, 1'b1);
    send_frame(8'h30, 1'b1);
    settle();
    check("t2_valid_cnt", valid_cnt, 3);
    check("t2_gap", last_valid_cyc - prev_valid_cyc, FRAME);
    check("t2_rx_data", bus.rx_data, 8'h30);
    check("t2_beep_flag", bus.beep_flag, 1'b0);

    // T3: other bytes hold, repeated ON idempotent
    send_frame(8'h31, 1'b1);
    send_frame(8'h41, 1'b1);
    settle();
    check("t3_rx_data_41", bus.rx_data, 8'h41);
    check("t3_beep_hold", bus.beep_flag, 1'b1);
    send_frame(8'h31, 1'b1);
    settle();
    check("t3_beep_repeat_on", bus.beep_flag, 1'b1);
    check("t3_valid_cnt", valid_cnt, 6);

    // T4: '0' with low stop bit is discarded
    send_frame(8'h30, 1'b0);
    drive_bit(1'b1, BIT);
    settle();
    check("t4_err_cnt", err_cnt, 1);
    check("t4_valid_cnt", valid_cnt, 6);
    check("t4_rx_data", bus.rx_data, 8'h31);
    check("t4_beep_flag", bus.beep_flag, 1'b1);

    // Break: line held low for three frames gives exactly one error
    drive_bit(1'b0, 3 * FRAME);
    settle();
    check("break_err_cnt", err_cnt, 2);
    check("break_state", bus.rx_state, IDLE);
    drive_bit(1'b1, 2 * BIT);
    settle();
    check("break_release_state", bus.rx_state, IDLE);
    check("break_valid_cnt", valid_cnt, 6);
    send_frame(8'h30, 1'b1);
    settle();
    check("after_break_rx_data", bus.rx_data, 8'h30);
    check("after_break_beep", bus.beep_flag, 1'b0);

    // T5: short low glitch is rejected
    drive_bit(1'b0, 15);
    drive_bit(1'b1, BIT);
    settle();
    check("t5_state", bus.rx_state, IDLE);
    check("t5_valid_cnt", valid_cnt, 7);
    check("t5_err_cnt", err_cnt, 2);
    send_frame(8'h31, 1'b1);
    settle();
    check("t5_rx_data", bus.rx_data, 8'h31);
    check("t5_beep_flag", bus.beep_flag, 1'b1);
    check("t5_valid_cnt_after", valid_cnt, 8);

    // T6: reset during data bit 4
    frame_b = 8'h31;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(frame_b[i], BIT);
    drive_bit(frame_b[4], BIT / 2);
    settle();
    check("t6_state_data", bus.rx_state, DATA);
    sys_rst_n = 1'b0;
    settle();
    check("t6_rst_rx_data", bus.rx_data, 8'h00);
    check("t6_rst_beep", bus.beep_flag, 1'b0);
    check("t6_rst_state", bus.rx_state, IDLE);
    check("t6_rst_strobes", {bus.rx_valid, bus.frame_err}, 2'b00);
    bus.uart_rxd = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    drive_bit(1'b1, 2 * BIT);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h31, 1'b1);
    settle();
    check("t6_valid_cnt", valid_cnt - v0, 1);
    check("t6_err_cnt", err_cnt - e0, 0);
    check("t6_rx_data", bus.rx_data, 8'h31);
    check("t6_beep_flag", bus.beep_flag, 1'b1);

    check("strobe_exclusion", excl_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
